// File: rtl/prom_nibble_loader_pkg.sv
// Shared constants and state encoding for the PROM nibble loader and its RAM.
package tempest_prom_pkg;

  localparam int PROM_DEPTH = 256;
  localparam int PROM_AW    = 8;
  localparam int PROM_DW    = 4;
  localparam int DL_AW      = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } prom_state_e;

  // Accepted-write counter stops at a full image so duplicates cannot wrap it.
  function automatic logic [PROM_AW:0] sat_inc(input logic [PROM_AW:0] count);
    if (count == (PROM_AW+1)'(PROM_DEPTH)) begin
      return count;
    end
    return count + 1'b1;
  endfunction

endpackage

// File: rtl/prom_nibble_loader_ram.sv
// 256x4 simple dual-port RAM: one write port, one registered read port with enable.
module prom_ram_256x4
  import tempest_prom_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [PROM_AW-1:0] waddr,
  input  logic [PROM_DW-1:0] wdata,
  input  logic               re,
  input  logic [PROM_AW-1:0] raddr,
  output logic [PROM_DW-1:0] rdata
);

  logic [PROM_DW-1:0] mem [PROM_DEPTH];

  // Contents survive reset so a partially loaded image is retained.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem yields the pre-write word on an address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prom_nibble_loader.sv
// Download-side loader for a 256x4 PROM replacement with a registered game read port.
// Optional checksum compare is built when PROM_LOADER_SUM_CHECK_EN is defined.
module prom_nibble_loader
  import tempest_prom_pkg::*;
#(
  parameter logic [DL_AW-1:0] BASE_ADDR    = 25'h0,
  parameter logic [7:0]       EXPECTED_SUM = 8'h00
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dl_en,
  input  logic               dl_wr,
  input  logic [DL_AW-1:0]   dl_addr,
  input  logic [7:0]         dl_data,
  output logic               dl_wait,
  input  logic               rd_cs,
  input  logic [PROM_AW-1:0] rd_addr,
  output logic [PROM_DW-1:0] rd_data,
  output logic               loaded,
  output logic [PROM_AW:0]   load_count,
  output logic               sum_ok,
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD = 2'(ST_LOAD);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);
  localparam logic [PROM_AW:0] FULL_COUNT = (PROM_AW+1)'(PROM_DEPTH);

  // Handshake: a strobe is taken only in a cycle where dl_wait is low; a
  // strobe while dl_wait is high is dropped with no effect.
  logic [1:0]         state;
  logic               wr_pend;
  logic [PROM_AW-1:0] wr_off;
  logic [PROM_DW-1:0] wr_nib;
  logic [DL_AW-1:0]   addr_diff;
  logic               in_window;
  logic               accept;
  logic               enter_load;
  logic               to_done;
  logic [PROM_AW:0]   count_next;
  logic               gate_q;
  logic [PROM_DW-1:0] ram_q;
  logic               unused_bits;

  // Unsigned offset below 256 covers both window bounds in one compare.
  assign addr_diff  = dl_addr - BASE_ADDR;
  assign in_window  = (addr_diff[DL_AW-1:PROM_AW] == '0);
  assign accept     = (state == S_LOAD) && dl_wr && !wr_pend && in_window;
  assign count_next = accept ? sat_inc(load_count) : load_count;
  assign enter_load = ((state == S_IDLE) || (state == S_DONE)) && dl_en;
  assign to_done    = (state == S_LOAD) && !dl_en && (count_next == FULL_COUNT);

  assign dl_wait     = wr_pend;
  assign fsm_state   = state;
  assign unused_bits = ^dl_data[7:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      load_count <= '0;
      loaded     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (dl_en) begin
            state      <= S_LOAD;
            load_count <= '0;
            loaded     <= 1'b0;
          end
        end
        S_LOAD: begin
          load_count <= count_next;
          if (!dl_en) begin
            if (count_next == FULL_COUNT) begin
              state  <= S_DONE;
              loaded <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Accepted byte is held one cycle and committed at the end of the busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pend <= 1'b0;
      wr_off  <= '0;
      wr_nib  <= '0;
    end else begin
      wr_pend <= accept;
      if (accept) begin
        wr_off <= addr_diff[PROM_AW-1:0];
        wr_nib <= dl_data[PROM_DW-1:0];
      end
    end
  end

`ifdef PROM_LOADER_SUM_CHECK_EN
  logic [7:0] sum;
  logic [7:0] sum_next;

  assign sum_next = sum + (accept ? {4'h0, dl_data[PROM_DW-1:0]} : 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum    <= '0;
      sum_ok <= 1'b0;
    end else if (enter_load) begin
      sum    <= '0;
      sum_ok <= 1'b0;
    end else if (state == S_LOAD) begin
      sum <= sum_next;
      if (to_done) begin
        sum_ok <= (sum_next == EXPECTED_SUM);
      end
    end
  end
`else
  logic unused_sum_cfg;

  assign sum_ok         = loaded;
  assign unused_sum_cfg = ^{EXPECTED_SUM, enter_load, to_done};
`endif

  // Gate flag is captured with the same enable as the RAM read, so rd_data
  // only changes on read edges and reads taken during LOAD come back as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q <= 1'b0;
    end else if (rd_cs) begin
      gate_q <= (state == S_LOAD);
    end
  end

  assign rd_data = gate_q ? '0 : ram_q;

  prom_ram_256x4 u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_pend),
    .waddr   (wr_off),
    .wdata   (wr_nib),
    .re      (rd_cs),
    .raddr   (rd_addr),
    .rdata   (ram_q)
  );

endmodule

// File: tb/tb_prom_nibble_loader.sv
// Directed and randomized bench for prom_nibble_loader against a session-level model.
module tb_prom_nibble_loader;

  localparam logic [24:0] BASE = 25'h1000;
  localparam logic [7:0]  EXP_SUM = 8'h00;
`ifdef PROM_LOADER_SUM_CHECK_EN
  localparam bit SUMCHK = 1'b1;
`else
  localparam bit SUMCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_en;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        rd_cs;
  logic [7:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        loaded;
  logic [8:0]  load_count;
  logic        sum_ok;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  // Reference model: session state, counters and the image as the spec defines them
  int         m_state;  // 0 idle, 1 loading, 2 done
  int         m_count;
  int         m_sum;
  bit         m_loaded;
  bit         m_sum_ok;
  logic [3:0] ref_mem [256];
  bit         ref_known [256];
  logic [3:0] exp_q [$];

  prom_nibble_loader #(.BASE_ADDR(BASE), .EXPECTED_SUM(EXP_SUM)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dl_en      (dl_en),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .rd_cs      (rd_cs),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .loaded     (loaded),
    .load_count (load_count),
    .sum_ok     (sum_ok),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [24:0] addr, input logic [7:0] data);
    int off;
    if (m_state == 1 && addr >= BASE && addr < BASE + 25'd256) begin
      off = int'(addr - BASE);
      ref_mem[off]   = data[3:0];
      ref_known[off] = 1'b1;
      if (m_count < 256) m_count++;
      m_sum = (m_sum + int'(data[3:0])) % 256;
    end
  endtask

  task automatic model_en(input bit v);
    if (v && m_state != 1) begin
      m_state = 1; m_count = 0; m_sum = 0; m_loaded = 0; m_sum_ok = 0;
    end else if (!v && m_state == 1) begin
      if (m_count == 256) begin
        m_state = 2; m_loaded = 1; m_sum_ok = (m_sum == int'(EXP_SUM));
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic set_en(input bit v);
    dl_en = v;
    @(negedge clk);
    model_en(v);
  endtask

  // One strobe followed by an idle cycle, so dl_wait is low at each strobe.
  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    dl_wr = 1'b1; dl_addr = addr; dl_data = data;
    model_accept(addr, data);
    @(negedge clk);
    dl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input logic [7:0] addr, input string tag);
    logic [3:0] e;
    rd_cs = 1'b1; rd_addr = addr;
    exp_q.push_back((m_state == 1) ? 4'h0 : ref_mem[addr]);
    @(negedge clk);
    rd_cs = 1'b0;
    e = exp_q.pop_front();
    check(tag, 32'(rd_data), 32'(e));
  endtask

  task automatic check_status(input string tag);
    check({tag, ".load_count"}, 32'(load_count), 32'(m_count));
    check({tag, ".loaded"}, 32'(loaded), 32'(m_loaded));
    check({tag, ".sum_ok"}, 32'(sum_ok), 32'(SUMCHK ? m_sum_ok : m_loaded));
  endtask

  initial begin
    logic [7:0] a;
    m_state = 0; m_count = 0; m_sum = 0; m_loaded = 0; m_sum_ok = 0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 4'h0; ref_known[i] = 1'b0; end
    reset_n = 1'b0; dl_en = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    rd_cs = 1'b0; rd_addr = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst.dl_wait", 32'(dl_wait), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    check_status("rst");
    reset_n = 1'b1;
    @(negedge clk);
    rd_cs = 1'b1; rd_addr = 8'h10;
    @(negedge clk);
    rd_cs = 1'b0;
    check("idle.rd_known", 32'($isunknown(rd_data)), 32'd0);

    // Full image, nibble = i & 15
    set_en(1'b1);
    check_status("full.start");
    for (int i = 0; i < 256; i++) strobe(BASE + 25'(i), 8'hA0 + 8'(i & 15));
    check("full.count_pre", 32'(load_count), 32'd256);
    check("full.loaded_pre", 32'(loaded), 32'd0);
    set_en(1'b0);
    check_status("full.end");
    read_check(8'h00, "full.rd00");
    read_check(8'h05, "full.rd05");
    read_check(8'hFF, "full.rdFF");

    // Window edges, upper nibble ignored
    set_en(1'b1);
    check_status("win.start");
    strobe(BASE - 25'd1, 8'hFB);
    strobe(BASE + 25'd256, 8'hFC);
    check("win.outliers", 32'(load_count), 32'd0);
    for (int i = 0; i < 256; i++) strobe(BASE + 25'(i), 8'hA0 | 8'((i * 7 + 3) & 15));
    set_en(1'b0);
    check_status("win.end");
    for (int i = 0; i < 256; i++) read_check(8'(i), "win.rd");

    // Back-to-back drop, gated reads during load, short session
    set_en(1'b1);
    read_check(8'h05, "gate.rd05");
    dl_wr = 1'b1; dl_addr = BASE + 25'd1; dl_data = 8'h0C;
    model_accept(BASE + 25'd1, 8'h0C);
    @(negedge clk);
    check("b2b.dl_wait", 32'(dl_wait), 32'd1);
    dl_addr = BASE + 25'd2; dl_data = 8'h0D;
    @(negedge clk);
    dl_wr = 1'b0;
    check("b2b.count", 32'(load_count), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 99; i++) strobe(BASE + 25'(3 + i), 8'($urandom));
    set_en(1'b0);
    check_status("short.end");
    read_check(8'h01, "b2b.rd01");
    read_check(8'h02, "b2b.rd02");

    // Checksum: 256 x 1 wraps to zero, then one nibble of 2
    for (int pass = 0; pass < 2; pass++) begin
      set_en(1'b1);
      for (int i = 0; i < 256; i++) strobe(BASE + 25'(i), (pass == 1 && i == 100) ? 8'h02 : 8'h01);
      set_en(1'b0);
      check_status(pass == 0 ? "sum.good" : "sum.bad");
    end

    // Random session with out-of-window addresses, duplicates and saturation
    set_en(1'b1);
    for (int i = 0; i < 300; i++) strobe(BASE - 25'd8 + 25'($urandom_range(0, 271)), 8'($urandom));
    set_en(1'b0);
    check_status("rand.end");
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      if (ref_known[a]) read_check(a, "rand.rd");
    end

    // dl_en falls in the cycle of the 256th accepted strobe
    set_en(1'b1);
    for (int i = 0; i < 255; i++) strobe(BASE + 25'(i), 8'($urandom));
    dl_wr = 1'b1; dl_addr = BASE + 25'd255; dl_data = 8'h57; dl_en = 1'b0;
    model_accept(BASE + 25'd255, 8'h57);
    @(negedge clk);
    model_en(1'b0);
    dl_wr = 1'b0;
    @(negedge clk);
    check_status("fall.end");
    read_check(8'hFF, "fall.rdFF");

    // Asynchronous reset in the middle of a session keeps RAM contents
    set_en(1'b1);
    for (int i = 0; i < 20; i++) strobe(BASE + 25'(i), 8'($urandom));
    @(posedge clk);
    #2;
    reset_n = 1'b0; dl_en = 1'b0;
    #1;
    m_state = 0; m_count = 0; m_sum = 0; m_loaded = 0; m_sum_ok = 0;
    check("arst.dl_wait", 32'(dl_wait), 32'd0);
    check("arst.rd_data", 32'(rd_data), 32'd0);
    check_status("arst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_check(8'h07, "arst.rd07");
    read_check(8'h80, "arst.rd80");
    check_status("arst.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
